dram_sequencer: RTL and testbench

- Owns the cartridge DRAM pins and sequences every DRAM cycle: host read/write accesses and CAS-before-RAS refresh.
- Arbitrates between the host port (the I/O-window logic) and an internal refresh scheduler that guarantees a refresh rate.
- Runs entirely on DotClk; all DRAM strobes and address lines are registered and glitch-free.

---
 rtl/dram_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_dram_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dram_sequencer.sv
// Cartridge DRAM sequencer: host read/write cycles and CBR refresh on DotClk, all pins registered.
// Host ack arrives T_CAS+3 clocks after grant; req is held until ack, refresh preempts once REF_URGENT credits are pending.
module dram_sequencer #(
    parameter int REF_DIV    = 128,
    parameter int REF_URGENT = 4,
    parameter int T_CAS      = 2,
    parameter int T_RP       = 2,
    parameter int T_RAS      = 3
) (
    input  logic        DotClk,
    input  logic        nRES,
    input  logic        req,
    input  logic        we,
    input  logic [10:0] row,
    input  logic [10:0] col,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        ref_overflow,
    output logic        nRAS,
    output logic        nCAS,
    output logic        nRWE,
    output logic [11:0] RA,
    input  logic [7:0]  RD_in,
    output logic [7:0]  RD_out,
    output logic        RD_oe
);

    localparam int DIV_W   = $clog2(REF_DIV);
    localparam int MAX_AB  = (T_CAS > T_RP) ? T_CAS : T_RP;
    localparam int CNT_MAX = (MAX_AB > T_RAS) ? MAX_AB : T_RAS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ROW, S_RAS, S_COL, S_CAS, S_PRE, S_REF_CAS, S_REF_RAS, S_REF_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         pending_q, pending_d;
    logic               ovf_q, ovf_d;
    logic               we_q, we_d;
    logic [10:0]        col_q, col_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               nras_q, nras_d;
    logic               ncas_q, ncas_d;
    logic               nrwe_q, nrwe_d;
    logic               oe_q, oe_d;
    logic [11:0]        ra_q, ra_d;
    logic               wrap;
    logic               start_ref;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        we_d      = we_q;
        col_d     = col_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        nras_d    = nras_q;
        ncas_d    = ncas_q;
        nrwe_d    = nrwe_q;
        oe_d      = oe_q;
        ra_d      = ra_q;
        start_ref = 1'b0;

        wrap  = (div_q == DIV_W'(REF_DIV - 1));
        div_d = wrap ? '0 : div_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (pending_q >= 3'(REF_URGENT) || (!req && pending_q != 3'd0)) begin
                    start_ref = 1'b1;
                    state_d   = S_REF_CAS;
                    ncas_d    = 1'b0;
                    nras_d    = 1'b1;
                end else if (req) begin
                    state_d = S_ROW;
                    we_d    = we;
                    col_d   = col;
                    wdata_d = wdata;
                    ra_d    = {1'b0, row};
                    nras_d  = 1'b1;
                end
            end
            S_ROW: begin
                state_d = S_RAS;
                nras_d  = 1'b0;
            end
            S_RAS: begin
                state_d = S_COL;
                ra_d    = {1'b0, col_q};
                nrwe_d  = ~we_q;
                oe_d    = we_q;
            end
            S_COL: begin
                state_d = S_CAS;
                ncas_d  = 1'b0;
                cnt_d   = '0;
            end
            S_CAS: begin
                if (cnt_q == CNT_W'(T_CAS - 1)) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                    nras_d  = 1'b1;
                    ncas_d  = 1'b1;
                    nrwe_d  = 1'b1;
                    oe_d    = 1'b0;
                    ack_d   = 1'b1;
                    if (!we_q) rdata_d = RD_in;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PRE: begin
                if (cnt_q == CNT_W'(T_RP - 1)) state_d = S_IDLE;
                else                           cnt_d   = cnt_q + 1'b1;
            end
            S_REF_CAS: begin
                state_d = S_REF_RAS;
                nras_d  = 1'b0;
            end
            S_REF_RAS: begin
                state_d = S_REF_HOLD;
                ncas_d  = 1'b1;
                cnt_d   = '0;
            end
            S_REF_HOLD: begin
                // nRAS stays low T_RAS-1 cycles here after the one REF_RAS cycle
                if (cnt_q == CNT_W'(T_RAS - 2)) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                    nras_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a credit arriving on the same edge a refresh starts cancels out
        if (wrap && !start_ref) begin
            if (pending_q == 3'd7) ovf_d     = 1'b1;
            else                   pending_d = pending_q + 3'd1;
        end else if (start_ref && !wrap) begin
            pending_d = pending_q - 3'd1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge DotClk or negedge nRES) begin
        if (!nRES) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            we_q      <= 1'b0;
            col_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            nras_q    <= 1'b1;
            ncas_q    <= 1'b1;
            nrwe_q    <= 1'b1;
            oe_q      <= 1'b0;
            ra_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            we_q      <= we_d;
            col_q     <= col_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            nras_q    <= nras_d;
            ncas_q    <= ncas_d;
            nrwe_q    <= nrwe_d;
            oe_q      <= oe_d;
            ra_q      <= ra_d;
        end
    end

    assign ack          = ack_q;
    assign rdata        = rdata_q;
    assign busy         = busy_q;
    assign ref_overflow = ovf_q;
    assign nRAS         = nras_q;
    assign nCAS         = ncas_q;
    assign nRWE         = nrwe_q;
    assign RA           = ra_q;
    assign RD_out       = wdata_q;
    assign RD_oe        = oe_q;

endmodule

// File: tb/tb_dram_sequencer.sv
// Bench for dram_sequencer: a default instance (u_a) and a fast-refresh instance (u_b, REF_DIV=4).
module tb_dram_sequencer;

    logic        DotClk = 1'b0;
    always #5 DotClk = ~DotClk;

    logic        nres_a, nres_b, req_a, req_b, we;
    logic [10:0] row, col;
    logic [7:0]  wdata, rd_in;

    logic        ack_a, busy_a, ovf_a, nras_a, ncas_a, nrwe_a, oe_a;
    logic [7:0]  rdata_a, rd_out_a;
    logic [11:0] ra_a;
    logic        ack_b, busy_b, ovf_b, nras_b, ncas_b, nrwe_b, oe_b;
    logic [7:0]  rdata_b, rd_out_b;
    logic [11:0] ra_b;

    dram_sequencer u_a (
        .DotClk(DotClk), .nRES(nres_a), .req(req_a), .we(we), .row(row), .col(col),
        .wdata(wdata), .ack(ack_a), .rdata(rdata_a), .busy(busy_a), .ref_overflow(ovf_a),
        .nRAS(nras_a), .nCAS(ncas_a), .nRWE(nrwe_a), .RA(ra_a), .RD_in(rd_in),
        .RD_out(rd_out_a), .RD_oe(oe_a)
    );

    dram_sequencer #(.REF_DIV(4)) u_b (
        .DotClk(DotClk), .nRES(nres_b), .req(req_b), .we(we), .row(row), .col(col),
        .wdata(wdata), .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .ref_overflow(ovf_b),
        .nRAS(nras_b), .nCAS(ncas_b), .nRWE(nrwe_b), .RA(ra_b), .RD_in(rd_in),
        .RD_out(rd_out_b), .RD_oe(oe_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge DotClk);
        #1;
    endtask

    // ctl = {nRAS, nCAS, nRWE, RD_oe, ack, busy}
    typedef struct packed {
        logic        req;
        logic        we;
        logic [10:0] row;
        logic [10:0] col;
        logic [7:0]  wdata;
        logic [7:0]  rd_in;
        logic [5:0]  ctl;
        logic [11:0] ra;
        logic [7:0]  rd_out;
        logic [7:0]  rdata;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int n;

        tbl[0]  = '{1'b1, 1'b1, 11'h155, 11'h2AA, 8'hA5, 8'h00, 6'b111001, 12'h155, 8'hA5, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 11'h155, 11'h2AA, 8'hA5, 8'h00, 6'b011001, 12'h155, 8'hA5, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 11'h155, 11'h2AA, 8'hA5, 8'h00, 6'b010101, 12'h2AA, 8'hA5, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 11'h155, 11'h2AA, 8'hA5, 8'h00, 6'b000101, 12'h2AA, 8'hA5, 8'h00};
        tbl[4]  = '{1'b1, 1'b1, 11'h155, 11'h2AA, 8'hA5, 8'h00, 6'b000101, 12'h2AA, 8'hA5, 8'h00};
        tbl[5]  = '{1'b1, 1'b1, 11'h155, 11'h2AA, 8'hA5, 8'h00, 6'b111011, 12'h2AA, 8'hA5, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 11'h155, 11'h2AA, 8'hA5, 8'h00, 6'b111001, 12'h2AA, 8'hA5, 8'h00};
        tbl[7]  = '{1'b0, 1'b1, 11'h155, 11'h2AA, 8'hA5, 8'h00, 6'b111000, 12'h2AA, 8'hA5, 8'h00};
        tbl[8]  = '{1'b1, 1'b0, 11'h7FF, 11'h001, 8'h5A, 8'h00, 6'b111001, 12'h7FF, 8'h5A, 8'h00};
        tbl[9]  = '{1'b1, 1'b0, 11'h7FF, 11'h001, 8'h5A, 8'h00, 6'b011001, 12'h7FF, 8'h5A, 8'h00};
        tbl[10] = '{1'b1, 1'b0, 11'h7FF, 11'h001, 8'h5A, 8'h00, 6'b011001, 12'h001, 8'h5A, 8'h00};
        tbl[11] = '{1'b1, 1'b0, 11'h7FF, 11'h001, 8'h5A, 8'h00, 6'b001001, 12'h001, 8'h5A, 8'h00};
        tbl[12] = '{1'b1, 1'b0, 11'h7FF, 11'h001, 8'h5A, 8'hC3, 6'b001001, 12'h001, 8'h5A, 8'h00};
        tbl[13] = '{1'b1, 1'b0, 11'h7FF, 11'h001, 8'h5A, 8'h3C, 6'b111011, 12'h001, 8'h5A, 8'h3C};
        tbl[14] = '{1'b0, 1'b0, 11'h7FF, 11'h001, 8'h5A, 8'hFF, 6'b111001, 12'h001, 8'h5A, 8'h3C};
        tbl[15] = '{1'b0, 1'b0, 11'h7FF, 11'h001, 8'h5A, 8'hFF, 6'b111000, 12'h001, 8'h5A, 8'h3C};

        nres_a = 1'b0; nres_b = 1'b0; req_a = 1'b0; req_b = 1'b0; we = 1'b0;
        row = '0; col = '0; wdata = '0; rd_in = '0;

        // reset state while nRES is held low
        #12;
        chk("rst_ctl", {nras_a, ncas_a, nrwe_a, oe_a, ack_a, busy_a, ovf_a}, 7'b1110000);
        chk("rst_data", {ra_a, rdata_a, rd_out_a}, 28'h0);
        chk("rst_pending", u_a.pending_q, 3'd0);
        #10 nres_a = 1'b1;

        // write then read, one record per DotClk
        for (int i = 0; i < 16; i++) begin
            req_a = tbl[i].req; we = tbl[i].we; row = tbl[i].row; col = tbl[i].col;
            wdata = tbl[i].wdata; rd_in = tbl[i].rd_in;
            step();
            chk($sformatf("vec%0d", i + 1),
                {nras_a, ncas_a, nrwe_a, oe_a, ack_a, busy_a, ra_a, rd_out_a, rdata_a},
                {tbl[i].ctl, tbl[i].ra, tbl[i].rd_out, tbl[i].rdata});
        end

        // asynchronous reset in the middle of a host CAS cycle
        req_a = 1'b1; we = 1'b1; row = 11'h0F0; col = 11'h00F; wdata = 8'h77;
        repeat (4) step();
        chk("midcas_pre", {nras_a, ncas_a, nrwe_a, oe_a, busy_a}, 5'b00011);
        req_a = 1'b0;
        #3 nres_a = 1'b0;
        #1;
        chk("midcas_rst_ctl", {nras_a, ncas_a, nrwe_a, oe_a, busy_a, ack_a}, 6'b111000);
        chk("midcas_rst_rdata", rdata_a, 8'h00);
        chk("midcas_rst_pending", u_a.pending_q, 3'd0);
        @(posedge DotClk);
        #3 nres_a = 1'b1;

        // idle after release: first credit at edge 128, refresh grant on the next edge
        n = 0;
        do begin
            step();
            n++;
        end while (ncas_a && n < 300);
        chk("first_ref_edge", n, 129);
        chk("ref_cas_first", {nras_a, ncas_a, nrwe_a, oe_a, ack_a}, 5'b10100);
        step(); chk("ref_ras",   {nras_a, ncas_a, nrwe_a, oe_a, ack_a}, 5'b00100);
        step(); chk("ref_hold1", {nras_a, ncas_a, nrwe_a, oe_a, ack_a}, 5'b01100);
        step(); chk("ref_hold2", {nras_a, ncas_a, nrwe_a, oe_a, ack_a}, 5'b01100);
        step(); chk("ref_pre",   {nras_a, ncas_a, nrwe_a, oe_a, ack_a}, 5'b11100);

        // u_b: grant at a wrap edge with req dropped after grant, then refresh at pending 2 on a wrap
        step();
        #3 nres_b = 1'b1;
        repeat (3) step();
        req_b = 1'b1; we = 1'b0; row = 11'h011; col = 11'h022;
        step();
        chk("wd_grant_busy", busy_b, 1'b1);
        req_b = 1'b0;
        for (int e = 5; e <= 12; e++) begin
            step();
            chk($sformatf("wd_ack_e%0d", e), ack_b, (e == 9));
            if (e == 8)  chk("coin_pending_before", u_b.pending_q, 3'd2);
            if (e == 11) chk("wd_busy_drop", busy_b, 1'b0);
            if (e == 12) begin
                chk("coin_ref_start", {nras_b, ncas_b}, 2'b10);
                chk("coin_pending_after", u_b.pending_q, 3'd2);
            end
        end

        // u_b: req held continuously; urgency takes over at pending 4 and credits saturate
        nres_b = 1'b0;
        step();
        #3 nres_b = 1'b1;
        req_b = 1'b1; we = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            step();
            chk($sformatf("pri_ack_e%0d", e), ack_b, (e == 6 || e == 14));
            case (e)
                17: chk("pri_ref_cas",   {nras_b, ncas_b}, 2'b10);
                18: chk("pri_ref_ras",   {nras_b, ncas_b}, 2'b00);
                19: chk("pri_ref_hold1", {nras_b, ncas_b}, 2'b01);
                20: chk("pri_ref_hold2", {nras_b, ncas_b}, 2'b01);
                21: chk("pri_ref_pre",   {nras_b, ncas_b}, 2'b11);
                55: chk("sat_ovf_before", ovf_b, 1'b0);
                56: begin
                    chk("sat_ovf_set", ovf_b, 1'b1);
                    chk("sat_pending", u_b.pending_q, 3'd7);
                end
                default: ;
            endcase
        end
        req_b = 1'b0;
        repeat (10) step();
        chk("sat_ovf_sticky", ovf_b, 1'b1);
        nres_b = 1'b0;
        #1;
        chk("sat_ovf_reset", ovf_b, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
